// File: rtl/complex_alu_pkg.sv
// ----------------------------------------------------------------------------
// complex_alu_pkg
// Shared definitions for the sequential complex-number ALU:
//   - command encodings (add / sub / mul / mul-by-conjugate)
//   - FSM state encoding
//   - partial-product index constants and helpers that describe how each
//     partial product contributes to the real/imaginary accumulators
// ----------------------------------------------------------------------------
package complex_alu_pkg;

  typedef enum logic [1:0] {
    CMD_ADD  = 2'b00,
    CMD_SUB  = 2'b01,
    CMD_MUL  = 2'b10,
    CMD_MULC = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Partial-product order through the shared multiplier
  localparam logic [1:0] PP_RR = 2'd0;  // ar*br
  localparam logic [1:0] PP_II = 2'd1;  // ai*bi
  localparam logic [1:0] PP_RI = 2'd2;  // ar*bi
  localparam logic [1:0] PP_IR = 2'd3;  // ai*br

  // First two partial products build the real part, the last two the imaginary
  function automatic logic pp_is_real(input logic [1:0] k);
    return (k == PP_RR) || (k == PP_II);
  endfunction

  // Plain multiply subtracts ai*bi; conjugate multiply subtracts ar*bi
  function automatic logic pp_negate(input logic conj, input logic [1:0] k);
    return conj ? (k == PP_RI) : (k == PP_II);
  endfunction

endpackage

// File: rtl/signed_mul_w.sv
// ----------------------------------------------------------------------------
// signed_mul_w
// Combinational W x W -> 2W signed multiplier (two's complement).
// Ports:
//   a_i  W-bit signed operand
//   b_i  W-bit signed operand
//   p_o  2W-bit signed product (always exact, never overflows)
// ----------------------------------------------------------------------------
module signed_mul_w #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  logic [2*W-1:0] a_ext_s;
  logic [2*W-1:0] b_ext_s;

  // Sign-extend first so the truncated 2W-bit product equals the exact product
  assign a_ext_s = {{W{a_i[W-1]}}, a_i};
  assign b_ext_s = {{W{b_i[W-1]}}, b_i};
  assign p_o     = a_ext_s * b_ext_s;

endmodule

// File: rtl/complex_alu_seq.sv
// ----------------------------------------------------------------------------
// complex_alu_seq
// Sequential complex ALU: add, sub, multiply, multiply-by-conjugate on W-bit
// re/im operands with valid/ready handshakes. Multiplies take four cycles
// through one shared signed_mul_w instance.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o  operand handshake (ready only in IDLE)
//   a_i, b_i                 operands {im, re}, two's complement
//   cmd_i                    00 add, 01 sub, 10 mul, 11 mul by conj(b)
//   out_valid_o / out_ready_i result handshake
//   result_re_o/result_im_o  2W-bit results
//   sat_o                    (COMPLEX_ALU_SAT_EN only) a component saturated
// Build option: define COMPLEX_ALU_SAT_EN for saturating arithmetic + sat_o.
// ----------------------------------------------------------------------------
module complex_alu_seq
  import complex_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [2*W-1:0] a_i,
  input  logic [2*W-1:0] b_i,
  input  logic [1:0]     cmd_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*W-1:0] result_re_o,
`ifdef COMPLEX_ALU_SAT_EN
  output logic [2*W-1:0] result_im_o,
  output logic           sat_o
`else
  output logic [2*W-1:0] result_im_o
`endif
);

  localparam int PW = 2 * W;
`ifdef COMPLEX_ALU_SAT_EN
  // Keep the carry bit so overflow can be detected and clamped
  localparam int AW = W + 1;
  localparam int MW = PW + 1;
`else
  localparam int AW = W;
  localparam int MW = PW;
`endif

  state_e          state_q,    state_d;
  logic [1:0]      k_q,        k_d;
  logic [PW-1:0]   a_q,        a_d;
  logic [PW-1:0]   b_q,        b_d;
  cmd_e            cmd_q,      cmd_d;
  logic [PW:0]     acc_re_q,   acc_re_d;
  logic [PW:0]     acc_im_q,   acc_im_d;
  logic [PW-1:0]   res_re_q,   res_re_d;
  logic [PW-1:0]   res_im_q,   res_im_d;
  logic            out_valid_q, out_valid_d;
`ifdef COMPLEX_ALU_SAT_EN
  logic            sat_q,      sat_d;
`endif

  logic [W-1:0]    ar_s, ai_s, br_s, bi_s;
  logic [W-1:0]    mul_x_s, mul_y_s;
  logic [PW-1:0]   pp_s;
  logic [PW:0]     pp_ext_s, term_s;
  logic [PW:0]     acc_re_nx_s, acc_im_nx_s;
  logic [AW-1:0]   add_re_s, add_im_s;

  // Sign-extend a W-bit component to the add-path width
  function automatic logic [AW-1:0] sx(input logic [W-1:0] v);
    return AW'($signed(v));
  endfunction

  // Reduce an add/sub sum to W bits (clamped when saturation is built in), then sign-extend
  function automatic logic [PW-1:0] fit_add(input logic [AW-1:0] s);
    logic [W-1:0] v;
`ifdef COMPLEX_ALU_SAT_EN
    if (s[W] != s[W-1]) begin
      v = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      v = s[W-1:0];
    end
`else
    v = s[W-1:0];
`endif
    return {{W{v[W-1]}}, v};
  endfunction

  // Reduce a multiply accumulator to 2W bits (clamped when saturation is built in)
  function automatic logic [PW-1:0] fit_mul(input logic [MW-1:0] s);
    logic [PW-1:0] v;
`ifdef COMPLEX_ALU_SAT_EN
    if (s[PW] != s[PW-1]) begin
      v = s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end else begin
      v = s[PW-1:0];
    end
`else
    v = s[PW-1:0];
`endif
    return v;
  endfunction

  assign ar_s = a_q[W-1:0];
  assign ai_s = a_q[PW-1:W];
  assign br_s = b_q[W-1:0];
  assign bi_s = b_q[PW-1:W];

  // Operand selection follows the PP_* order: rr, ii, ri, ir
  assign mul_x_s = ((k_q == PP_RR) || (k_q == PP_RI)) ? ar_s : ai_s;
  assign mul_y_s = ((k_q == PP_RR) || (k_q == PP_IR)) ? br_s : bi_s;

  signed_mul_w #(.W(W)) u_mul (
    .a_i (mul_x_s),
    .b_i (mul_y_s),
    .p_o (pp_s)
  );

  assign pp_ext_s    = {pp_s[PW-1], pp_s};
  assign term_s      = pp_negate(cmd_q[0], k_q) ? ({(PW+1){1'b0}} - pp_ext_s) : pp_ext_s;
  assign acc_re_nx_s = acc_re_q + term_s;
  assign acc_im_nx_s = acc_im_q + term_s;

  assign add_re_s = cmd_q[0] ? (sx(ar_s) - sx(br_s)) : (sx(ar_s) + sx(br_s));
  assign add_im_s = cmd_q[0] ? (sx(ai_s) - sx(bi_s)) : (sx(ai_s) + sx(bi_s));

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    cmd_d       = cmd_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    res_re_d    = res_re_q;
    res_im_d    = res_im_q;
    out_valid_d = out_valid_q;
`ifdef COMPLEX_ALU_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          cmd_d    = cmd_e'(cmd_i);
          k_d      = PP_RR;
          acc_re_d = {(PW+1){1'b0}};
          acc_im_d = {(PW+1){1'b0}};
          state_d  = cmd_i[1] ? ST_MUL : ST_ADD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADD: begin
        res_re_d    = fit_add(add_re_s);
        res_im_d    = fit_add(add_im_s);
        out_valid_d = 1'b1;
`ifdef COMPLEX_ALU_SAT_EN
        sat_d       = (add_re_s[W] ^ add_re_s[W-1]) | (add_im_s[W] ^ add_im_s[W-1]);
`endif
        state_d     = ST_DONE;
      end
      ST_MUL: begin
        if (pp_is_real(k_q)) begin
          acc_re_d = acc_re_nx_s;
        end else begin
          acc_im_d = acc_im_nx_s;
        end
        k_d = k_q + 2'd1;
        if (k_q == PP_IR) begin
          // Real part completed at k=1; imaginary part completes with this product
          res_re_d    = fit_mul(acc_re_q[MW-1:0]);
          res_im_d    = fit_mul(acc_im_nx_s[MW-1:0]);
          out_valid_d = 1'b1;
`ifdef COMPLEX_ALU_SAT_EN
          sat_d       = (acc_re_q[PW] ^ acc_re_q[PW-1]) | (acc_im_nx_s[PW] ^ acc_im_nx_s[PW-1]);
`endif
          state_d     = ST_DONE;
        end else begin
          state_d     = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
`ifdef COMPLEX_ALU_SAT_EN
          sat_d       = 1'b0;
`endif
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      a_q         <= {PW{1'b0}};
      b_q         <= {PW{1'b0}};
      cmd_q       <= CMD_ADD;
      acc_re_q    <= {(PW+1){1'b0}};
      acc_im_q    <= {(PW+1){1'b0}};
      res_re_q    <= {PW{1'b0}};
      res_im_q    <= {PW{1'b0}};
      out_valid_q <= 1'b0;
`ifdef COMPLEX_ALU_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cmd_q       <= cmd_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      out_valid_q <= out_valid_d;
`ifdef COMPLEX_ALU_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_re_o = res_re_q;
  assign result_im_o = res_im_q;
`ifdef COMPLEX_ALU_SAT_EN
  assign sat_o       = sat_q;
`endif

endmodule

// File: tb/tb_complex_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_complex_alu_seq
// Self-checking bench for complex_alu_seq (W=4): directed cases from the test
// plan, a mid-multiply reset, then randomized operations compared against a
// behavioural complex-arithmetic model. Honours COMPLEX_ALU_SAT_EN.
// ----------------------------------------------------------------------------
module tb_complex_alu_seq;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] a_in;
  logic [PW-1:0] b_in;
  logic [1:0]    cmd_in;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] res_re;
  logic [PW-1:0] res_im;
`ifdef COMPLEX_ALU_SAT_EN
  logic          sat;
`endif

  int n_checks = 0;
  int n_err    = 0;

  complex_alu_seq #(.W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .cmd_i       (cmd_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_re_o (res_re),
`ifdef COMPLEX_ALU_SAT_EN
    .result_im_o (res_im),
    .sat_o       (sat)
`else
    .result_im_o (res_im)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the run must never hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? (int'(v) - (1 << W)) : int'(v);
  endfunction

  function automatic int wrap(input int x, input int bits);
    int m;
    int r;
    m = 1 << bits;
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic int clamp(input int x, input int bits);
    int lo;
    int hi;
    lo = -(1 << (bits - 1));
    hi = (1 << (bits - 1)) - 1;
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Complex arithmetic straight from the operation definitions
  task automatic model(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [1:0] cmd,
                       output logic [PW-1:0] re, output logic [PW-1:0] im, output logic s);
    int ar, ai, br, bi, xr, xi, bits;
    ar = sx(a[W-1:0]);  ai = sx(a[PW-1:W]);
    br = sx(b[W-1:0]);  bi = sx(b[PW-1:W]);
    if (!cmd[1]) begin
      xr = cmd[0] ? ar - br : ar + br;
      xi = cmd[0] ? ai - bi : ai + bi;
      bits = W;
    end else if (!cmd[0]) begin
      xr = ar * br - ai * bi;
      xi = ar * bi + ai * br;
      bits = PW;
    end else begin
      xr = ar * br + ai * bi;
      xi = ai * br - ar * bi;
      bits = PW;
    end
    s = 1'b0;
`ifdef COMPLEX_ALU_SAT_EN
    s  = (xr != clamp(xr, bits)) || (xi != clamp(xi, bits));
    xr = clamp(xr, bits);
    xi = clamp(xi, bits);
`endif
    re = PW'(wrap(xr, bits));
    im = PW'(wrap(xi, bits));
  endtask

  // One full transaction; called at a negedge with the DUT idle
  task automatic do_op(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [1:0] cmd,
                       input int hold);
    logic [PW-1:0] e_re, e_im;
    logic          e_sat;
    int            lat;
    model(a, b, cmd, e_re, e_im, e_sat);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    cmd_in    = cmd;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    lat = 1;
    check("in_ready_busy", in_ready, 0);
    while (!out_valid && lat < 20) begin
      // Garbage on inputs while busy must be ignored
      in_valid  = 1'($urandom_range(0, 1));
      a_in      = PW'($urandom);
      b_in      = PW'($urandom);
      cmd_in    = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", lat, cmd[1] ? 5 : 2);
    check("result_re", res_re, e_re);
    check("result_im", res_im, e_im);
`ifdef COMPLEX_ALU_SAT_EN
    check("sat", sat, e_sat);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_re", res_re, e_re);
      check("hold_im", res_im, e_im);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_hs", in_ready, 1);
    check("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cmd_in    = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_re", res_re, 0);
    check("rst_im", res_im, 0);
    rst = 1'b0;

    // Directed: A=3/2, B=-1/4
    do_op(8'h23, 8'h4F, 2'b00, 0);
    check("plan_add_re", res_re, 8'h02);
    do_op(8'h23, 8'h4F, 2'b01, 0);
    do_op(8'h23, 8'h4F, 2'b10, 0);
    do_op(8'h23, 8'h4F, 2'b11, 0);
    // Overflow cases
    do_op(8'h77, 8'h77, 2'b00, 0);
    do_op(8'h88, 8'h88, 2'b10, 0);
    do_op(8'h88, 8'h88, 2'b11, 0);
    // Backpressure for 10 cycles
    do_op(8'h23, 8'h4F, 2'b10, 10);

    // Reset in the middle of a multiply (k=2)
    in_valid = 1'b1; a_in = 8'h23; b_in = 8'h4F; cmd_in = 2'b10;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_re", res_re, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    do_op(8'h23, 8'h4F, 2'b00, 1);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      do_op(PW'($urandom), PW'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
